// File: rtl/axi_ag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_ag_pkg
// Description : Shared types and constants for the AXI burst address generator.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_ag_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned c_PAGE_BITS = 12;
    localparam int unsigned c_CNT_W     = 16;

endpackage
`default_nettype wire

// File: rtl/axi_ag_decode.sv
`default_nettype none
// ============================================================================
// Module      : axi_ag_decode
// Description : Combinational command decode: legality, step, beat count, wrap mask.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_ag_decode
    import axi_ag_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int P_SIZE = 4
) (
    input  logic [c_PAGE_BITS-1:0] i_addr_lo,
    input  logic [7:0]             i_len,
    input  logic [2:0]             i_size,
    input  logic [1:0]             i_burst,
    output logic                   o_legal,
    output logic [2:0]             o_step_log2,
    output logic [c_CNT_W-1:0]     o_beats_m1,
    output logic [ADDR_W-1:0]      o_wrap_mask
);

    localparam int             c_SPAN_W     = c_CNT_W + 1;
    localparam logic [2:0]     c_PSIZE      = 3'(P_SIZE);
    localparam logic [c_SPAN_W-1:0] c_PAGE_BYTES = c_SPAN_W'(1) << c_PAGE_BITS;

    logic [7:0]             w_size_mask;
    logic [c_SPAN_W-1:0]    w_span;
    logic [c_PAGE_BITS-1:0] w_page_lo;
    logic                   w_cross;
    logic                   w_wrap_len_ok;
    logic                   w_wrap_aligned;
    logic [2:0]             w_shift;

    assign w_size_mask = (8'd1 << i_size) - 8'd1;
    // Total burst bytes; 256 beats of 128 bytes still fits in c_SPAN_W bits.
    assign w_span      = ({{(c_SPAN_W-8){1'b0}}, i_len} + c_SPAN_W'(1)) << i_size;
    assign w_page_lo   = i_addr_lo & ~{4'd0, w_size_mask};
    assign w_cross     = ({{(c_SPAN_W-c_PAGE_BITS){1'b0}}, w_page_lo} + w_span) > c_PAGE_BYTES;

    assign w_wrap_len_ok  = (i_len == 8'd1) || (i_len == 8'd3) || (i_len == 8'd7) || (i_len == 8'd15);
    assign w_wrap_aligned = (i_addr_lo[7:0] & w_size_mask) == 8'd0;

    assign w_shift     = (i_size > c_PSIZE) ? (i_size - c_PSIZE) : 3'd0;
    assign o_step_log2 = (i_size > c_PSIZE) ? c_PSIZE : i_size;
    assign o_beats_m1  = (({{(c_CNT_W-8){1'b0}}, i_len} + c_CNT_W'(1)) << w_shift) - c_CNT_W'(1);
    assign o_wrap_mask = ADDR_W'(w_span - c_SPAN_W'(1));

    always_comb begin
        o_legal = 1'b0;
        case (burst_e'(i_burst))
            BURST_FIXED: o_legal = 1'b1;
            BURST_INCR:  o_legal = !w_cross;
            BURST_WRAP:  o_legal = w_wrap_len_ok && w_wrap_aligned;
            default:     o_legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_addr_gen
// Description : Splits an AXI burst command into peripheral-width beat addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen
    import axi_ag_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int P_SIZE = 4,
    localparam int LANE_W = (P_SIZE > 0) ? P_SIZE : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [7:0]        LEN,
    input  logic [2:0]        SIZE,
    input  logic [1:0]        BURST,
    output logic              BEAT_VALID,
    input  logic              BEAT_READY,
    output logic [ADDR_W-1:0] BEAT_ADDR,
    output logic [LANE_W-1:0] BEAT_LANE,
    output logic              BEAT_LAST,
    output logic              ERR
);

    logic                w_legal;
    logic [2:0]          w_step_log2;
    logic [c_CNT_W-1:0]  w_beats_m1;
    logic [ADDR_W-1:0]   w_wrap_mask;
    logic [ADDR_W-1:0]   w_step;
    logic [ADDR_W-1:0]   w_next_addr;

    state_e              r_state;
    burst_e              r_burst;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_mask;
    logic [2:0]          r_step_log2;
    logic [c_CNT_W-1:0]  r_remain;
    logic                r_valid;
    logic                r_last;
    logic                r_err;

    axi_ag_decode #(
        .ADDR_W (ADDR_W),
        .P_SIZE (P_SIZE)
    ) u_decode (
        .i_addr_lo   (ADDR[c_PAGE_BITS-1:0]),
        .i_len       (LEN),
        .i_size      (SIZE),
        .i_burst     (BURST),
        .o_legal     (w_legal),
        .o_step_log2 (w_step_log2),
        .o_beats_m1  (w_beats_m1),
        .o_wrap_mask (w_wrap_mask)
    );

    assign w_step = ADDR_W'(1) << r_step_log2;

    // Wrap keeps the bits above the mask fixed, so the current address supplies the base.
    always_comb begin
        w_next_addr = r_addr;
        case (r_burst)
            BURST_INCR: w_next_addr = (r_addr & ~(w_step - ADDR_W'(1))) + w_step;
            BURST_WRAP: w_next_addr = (r_addr & ~r_mask) | ((r_addr + w_step) & r_mask);
            default:    w_next_addr = r_addr;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_burst     <= BURST_FIXED;
            r_addr      <= '0;
            r_mask      <= '0;
            r_step_log2 <= '0;
            r_remain    <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        if (w_legal) begin
                            r_state     <= ST_RUN;
                            r_burst     <= burst_e'(BURST);
                            r_addr      <= ADDR;
                            r_mask      <= w_wrap_mask;
                            r_step_log2 <= w_step_log2;
                            r_remain    <= w_beats_m1;
                            r_valid     <= 1'b1;
                            r_last      <= (w_beats_m1 == '0);
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (BEAT_READY) begin
                        if (r_last) begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                        end else begin
                            r_addr   <= w_next_addr;
                            r_remain <= r_remain - c_CNT_W'(1);
                            r_last   <= (r_remain == c_CNT_W'(1));
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    generate
        if (P_SIZE > 0) begin : g_lane_bytes
            assign BEAT_LANE = r_addr[LANE_W-1:0];
        end else begin : g_lane_none
            assign BEAT_LANE = 1'b0;
        end
    endgenerate

    assign CMD_READY  = (r_state == ST_IDLE);
    assign BEAT_VALID = r_valid;
    assign BEAT_ADDR  = r_addr;
    assign BEAT_LAST  = r_last;
    assign ERR        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_burst_addr_gen
// Description : Directed self-checking bench for axi_burst_addr_gen (P_SIZE=4, ADDR_W=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_addr_gen;

    localparam int ADDR_W = 32;
    localparam int P_SIZE = 4;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              CMD_VALID;
    logic              CMD_READY;
    logic [ADDR_W-1:0] ADDR;
    logic [7:0]        LEN;
    logic [2:0]        SIZE;
    logic [1:0]        BURST;
    logic              BEAT_VALID;
    logic              BEAT_READY;
    logic [ADDR_W-1:0] BEAT_ADDR;
    logic [P_SIZE-1:0] BEAT_LANE;
    logic              BEAT_LAST;
    logic              ERR;

    int                n_cmp = 0;
    int                n_bad = 0;
    logic [31:0]       exp_q[$];

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W),
        .P_SIZE (P_SIZE)
    ) u_dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .ADDR       (ADDR),
        .LEN        (LEN),
        .SIZE       (SIZE),
        .BURST      (BURST),
        .BEAT_VALID (BEAT_VALID),
        .BEAT_READY (BEAT_READY),
        .BEAT_ADDR  (BEAT_ADDR),
        .BEAT_LANE  (BEAT_LANE),
        .BEAT_LAST  (BEAT_LAST),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
        CMD_VALID = 1'b1;
        ADDR      = a;
        LEN       = l;
        SIZE      = s;
        BURST     = b;
        chk("cmd_ready_idle", 32'(CMD_READY), 32'd1);
        tick();
        CMD_VALID = 1'b0;
    endtask

    task automatic check_beat(input string tag, input logic [31:0] ea, input bit last);
        logic [3:0] el;
        el = ea[3:0];
        chk({tag, "_valid"}, 32'(BEAT_VALID), 32'd1);
        chk({tag, "_addr"},  BEAT_ADDR, ea);
        chk({tag, "_lane"},  32'(BEAT_LANE), 32'(el));
        chk({tag, "_last"},  32'(BEAT_LAST), 32'(last));
        chk({tag, "_busy"},  32'(CMD_READY), 32'd0);
    endtask

    // Expected beat addresses come from exp_q; optional stall and stray commands mid-burst.
    task automatic run_burst(input string name, input logic [31:0] a, input logic [7:0] l,
                             input logic [2:0] s, input logic [1:0] b,
                             input int stall_k, input bit noise);
        int n;
        n = exp_q.size();
        send(a, l, s, b);
        for (int k = 0; k < n; k++) begin
            check_beat($sformatf("%s_b%0d", name, k), exp_q[k], k == n - 1);
            if (noise && k == 0) begin
                CMD_VALID = 1'b1;
                ADDR      = 32'h0000_ABC0;
                LEN       = 8'd0;
                SIZE      = 3'd2;
                BURST     = 2'b01;
            end
            if (noise && k == n - 1) CMD_VALID = 1'b0;
            if (k == stall_k) begin
                BEAT_READY = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    tick();
                    check_beat($sformatf("%s_hold%0d", name, h), exp_q[k], k == n - 1);
                end
                BEAT_READY = 1'b1;
            end
            tick();
        end
        chk({name, "_done_ready"}, 32'(CMD_READY), 32'd1);
        chk({name, "_done_valid"}, 32'(BEAT_VALID), 32'd0);
    endtask

    task automatic err_cmd(input string name, input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b);
        send(a, l, s, b);
        chk({name, "_err"},   32'(ERR), 32'd1);
        chk({name, "_valid"}, 32'(BEAT_VALID), 32'd0);
        chk({name, "_ready"}, 32'(CMD_READY), 32'd1);
        tick();
        chk({name, "_err_off"}, 32'(ERR), 32'd0);
        chk({name, "_valid2"},  32'(BEAT_VALID), 32'd0);
    endtask

    initial begin
        RESET      = 1'b1;
        CMD_VALID  = 1'b0;
        ADDR       = '0;
        LEN        = '0;
        SIZE       = '0;
        BURST      = '0;
        BEAT_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;

        chk("rst_cmd_ready", 32'(CMD_READY), 32'd1);
        chk("rst_valid",     32'(BEAT_VALID), 32'd0);
        chk("rst_last",      32'(BEAT_LAST), 32'd0);
        chk("rst_err",       32'(ERR), 32'd0);
        chk("rst_addr",      BEAT_ADDR, 32'd0);
        chk("rst_lane",      32'(BEAT_LANE), 32'd0);

        exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
        run_burst("incr4", 32'h100, 8'd3, 3'd2, 2'b01, -1, 1'b0);

        exp_q = '{32'h38, 32'h20, 32'h28, 32'h30};
        run_burst("wrap4", 32'h38, 8'd3, 3'd3, 2'b10, -1, 1'b1);

        exp_q = '{32'h40, 32'h50, 32'h60, 32'h70};
        run_burst("oversz", 32'h40, 8'd1, 3'd5, 2'b01, -1, 1'b0);

        exp_q = '{32'hFE0, 32'hFE8, 32'hFF0, 32'hFF8};
        run_burst("pg_edge", 32'hFE0, 8'd3, 3'd3, 2'b01, -1, 1'b0);

        exp_q = '{32'h10};
        run_burst("single", 32'h10, 8'd0, 3'd2, 2'b01, -1, 1'b0);

        err_cmd("e_4k",    32'hFF0, 8'd3, 3'd3, 2'b01);
        err_cmd("e_rsvd",  32'h100, 8'd1, 3'd2, 2'b11);
        err_cmd("e_wlen",  32'h100, 8'd2, 3'd2, 2'b10);
        err_cmd("e_walgn", 32'h34,  8'd3, 3'd3, 2'b10);

        exp_q = '{32'h204, 32'h204, 32'h204};
        run_burst("fixed", 32'h204, 8'd2, 3'd2, 2'b00, 1, 1'b0);

        // Reset while beat 2 of an eight-beat INCR is presented.
        send(32'h300, 8'd7, 3'd2, 2'b01);
        tick();
        tick();
        check_beat("mid_b2", 32'h308, 1'b0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("mid_rst_valid", 32'(BEAT_VALID), 32'd0);
        chk("mid_rst_addr",  BEAT_ADDR, 32'd0);
        chk("mid_rst_lane",  32'(BEAT_LANE), 32'd0);
        chk("mid_rst_last",  32'(BEAT_LAST), 32'd0);
        chk("mid_rst_err",   32'(ERR), 32'd0);
        chk("mid_rst_ready", 32'(CMD_READY), 32'd1);

        exp_q = '{32'h500, 32'h504};
        run_burst("after_rst", 32'h500, 8'd1, 3'd2, 2'b01, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
